imem_uart_loader: RTL and testbench
===================================

// Module: imem_uart_loader
// PURPOSE
//  Writer side of the CPU instruction memory: receives a program image over the UART RX byte stream
//  and writes 32-bit words into the instruction RAM that the fetch stage reads (byte addr, addr[9:2]).
//  Holds the CPU in reset while loading. Sits between uart_rx and the instruction RAM write port.
// PARAMETERS
//  ADDR_BITS      8         word-address width of instruction RAM (capacity 2^ADDR_BITS words)
//  TIMEOUT_CYCLES 1000000   max clk cycles between bytes inside a frame before abort
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  rx_data    in   8   received byte from uart_rx
//  rx_valid   in   1   1-cycle strobe: rx_data valid this cycle
//  wr_en      out  1   instruction RAM write strobe (1 cycle per word)
//  wr_addr    out  32  byte address, word aligned: {zeros, word_idx[ADDR_BITS-1:0], 2'b00}
//  wr_data    out  32  instruction word
//  cpu_hold   out  1   high = CPU held in reset
//  load_done  out  1   1-cycle pulse on successful frame
//  load_error out  1   level, high while in ERR
// BEHAVIOUR
//  Frame: 0xA5 | N[15:8] | N[7:0] | N words, 4 bytes each MSB first | CSUM.
//   CSUM = XOR of all 4*N data bytes (count bytes excluded).
//  Reset: all outputs 0; state IDLE; word_idx, byte_cnt, timer, csum cleared. Reset mid-frame aborts
//   immediately; RAM contents already written are not restored.
//  All outputs registered; a byte is accepted on the edge where rx_valid=1.
//  States:
//   IDLE   : non-0xA5 bytes ignored; 0xA5 -> CNT_HI, cpu_hold<=1, csum<=0, word_idx<=0.
//   CNT_HI : byte -> N[15:8]; -> CNT_LO.
//   CNT_LO : byte -> N[7:0]; N==0 -> CSUM; N>2^ADDR_BITS -> ERR; else -> DATA.
//   DATA   : shift byte into word (MSB first), csum^=byte. On 4th byte of a word: next cycle
//            wr_en=1, wr_data=word, wr_addr=word_idx<<2; word_idx++ after write. After word N -> CSUM.
//   CSUM   : byte==csum -> DONE, else -> ERR.
//   DONE   : load_done=1 and cpu_hold=0 for this cycle; -> IDLE next cycle.
//   ERR    : load_error=1, cpu_hold stays 1; only a 0xA5 byte leaves ERR (-> CNT_HI as from IDLE).
//  wr_en is never high for two consecutive cycles (min 4 bytes between writes).
//  Timeout: timer clears on every accepted byte; counts in CNT_HI/CNT_LO/DATA/CSUM; reaching
//   TIMEOUT_CYCLES -> ERR. Not counted in IDLE/DONE/ERR.
//  N==2^ADDR_BITS legal (fills RAM); word_idx never wraps within a frame.
//  0xA5 inside CNT/DATA/CSUM is data, not a restart.
//  rx_valid on the same cycle as a timeout: timeout wins, byte is dropped.
// TESTING
//  1 Frame A5 00 02 08 00 00 03 20 04 40 00 6F -> wr_en@addr 0x0 data 0x08000003, wr_en@addr 0x4 data
//    0x20044000, load_done pulse, cpu_hold 1 from header to DONE then 0.
//  2 Same frame with CSUM 0x6E -> both writes occur, load_error=1, cpu_hold stays 1; resend good
//    frame -> load_done, load_error=0.
//  3 Bytes 00 FF 13 before A5 00 00 00 -> garbage ignored, no wr_en, load_done pulse.
//  4 A5 01 01 (N=257, ADDR_BITS=8) -> ERR after 3rd byte, no wr_en.
//  5 A5 00 01 08 00 then silence TIMEOUT_CYCLES (use 50) -> ERR, no wr_en; reset -> all outputs 0.
//  6 Full 256-word frame -> last write addr 0x3FC; wr_en pulses separated by >=1 idle cycle.

Source files
------------

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART program-image loader writing 32-bit words into instruction RAM
// Frame: A5 | N hi | N lo | N words MSB-first | XOR checksum of data bytes.
module imem_uart_loader #(
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_BITS);
  localparam logic [31:0] TIMER_MAX = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [16:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] timer_q, timer_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;

  logic        counting;
  logic        timeout;
  logic [15:0] n_full;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    csum_d       = csum_q;
    timer_d      = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    n_full       = {n_q[15:8], rx_data};

    counting = (state_q == CNT_HI) || (state_q == CNT_LO) ||
               (state_q == DATA)   || (state_q == CSUM);
    timeout  = counting && (timer_q >= TIMER_MAX);

    if (counting && !rx_valid) begin
      timer_d = timer_q + 32'd1;
    end

    // A timeout outranks a byte arriving in the same cycle; that byte is dropped.
    if (timeout) begin
      state_d = ERR;
    end else begin
      case (state_q)
        IDLE, ERR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d    = CNT_HI;
            csum_d     = '0;
            word_idx_d = '0;
            byte_cnt_d = '0;
          end
        end
        CNT_HI: begin
          if (rx_valid) begin
            n_d     = {rx_data, n_q[7:0]};
            state_d = CNT_LO;
          end
        end
        CNT_LO: begin
          if (rx_valid) begin
            n_d        = n_full;
            byte_cnt_d = '0;
            if (n_full == 16'd0) begin
              state_d = CSUM;
            end else if ({1'b0, n_full} > MAX_WORDS) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid) begin
            word_d     = {word_q[15:0], rx_data};
            csum_d     = csum_q ^ rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_en_d    = 1'b1;
              wr_data_d  = {word_q, rx_data};
              wr_addr_d  = {{(30 - ADDR_BITS){1'b0}}, word_idx_q[ADDR_BITS-1:0], 2'b00};
              word_idx_d = word_idx_q + 17'd1;
              if (word_idx_q + 17'd1 == {1'b0, n_q}) begin
                state_d = CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (rx_valid) begin
            state_d = (rx_data == csum_q) ? DONE : ERR;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Status outputs follow the state being entered so they are registered with it.
    load_done_d  = (state_d == DONE);
    load_error_d = (state_d == ERR);
    cpu_hold_d   = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      timer_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      timer_q      <= timer_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - directed bench for imem_uart_loader
module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  imem_uart_loader #(.ADDR_BITS(8), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          consec_cnt = 0;
  logic        prev_wr = 1'b0;
  logic        hold_at_done = 1'b1;
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      if (prev_wr) consec_cnt++;
    end
    prev_wr = wr_en;
    if (load_done) begin
      done_cnt++;
      hold_at_done = cpu_hold;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    #1;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    consec_cnt = 0;
    hold_at_done = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_queue();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic load_good_frame();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03,
             8'h20, 8'h04, 8'h40, 8'h00, 8'h6F};
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, ~k, 8'h5A, k ^ 8'h3C};
  endfunction

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          bad;

    do_reset();
    #1;
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_load_done", {31'b0, load_done}, 32'd0);
    check("rst_load_error", {31'b0, load_error}, 32'd0);

    // Good two-word frame
    clear_mon();
    send_byte(8'hA5);
    check("t1_hold_after_hdr", {31'b0, cpu_hold}, 32'd1);
    tx_q = '{8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h20, 8'h04, 8'h40, 8'h00, 8'h6F};
    send_queue();
    check("t1_wr_count", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      check("t1_addr0", wa_q[0], 32'h0);
      check("t1_data0", wd_q[0], 32'h08000003);
      check("t1_addr1", wa_q[1], 32'h4);
      check("t1_data1", wd_q[1], 32'h20044000);
    end
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_hold_at_done", {31'b0, hold_at_done}, 32'd0);
    check("t1_hold_after", {31'b0, cpu_hold}, 32'd0);
    check("t1_error", {31'b0, load_error}, 32'd0);

    // Bad checksum then recovery
    clear_mon();
    load_good_frame();
    tx_q[11] = 8'h6E;
    send_queue();
    check("t2_wr_count", wa_q.size(), 32'd2);
    check("t2_error", {31'b0, load_error}, 32'd1);
    check("t2_hold", {31'b0, cpu_hold}, 32'd1);
    check("t2_done_cnt", done_cnt, 32'd0);
    clear_mon();
    load_good_frame();
    send_queue();
    check("t2_rec_done_cnt", done_cnt, 32'd1);
    check("t2_rec_error", {31'b0, load_error}, 32'd0);
    check("t2_rec_hold", {31'b0, cpu_hold}, 32'd0);

    // Garbage before sync, empty frame
    clear_mon();
    tx_q = '{8'h00, 8'hFF, 8'h13};
    send_queue();
    check("t3_hold_garbage", {31'b0, cpu_hold}, 32'd0);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_queue();
    check("t3_wr_count", wa_q.size(), 32'd0);
    check("t3_done_cnt", done_cnt, 32'd1);

    // Sync byte value inside data is plain data
    clear_mon();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    send_queue();
    check("t3b_wr_count", wa_q.size(), 32'd1);
    if (wd_q.size() == 1) check("t3b_data", wd_q[0], 32'hA5A5A5A5);
    check("t3b_done_cnt", done_cnt, 32'd1);

    // N=257 exceeds capacity
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    check("t4_err_before", {31'b0, load_error}, 32'd0);
    send_byte(8'h01);
    check("t4_err_after", {31'b0, load_error}, 32'd1);
    repeat (3) @(negedge clk);
    check("t4_wr_count", wa_q.size(), 32'd0);

    // Inter-byte timeout
    do_reset();
    clear_mon();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h08, 8'h00};
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
    repeat (40) @(negedge clk);
    check("t5_no_err_yet", {31'b0, load_error}, 32'd0);
    check("t5_hold_waiting", {31'b0, cpu_hold}, 32'd1);
    repeat (20) @(negedge clk);
    check("t5_err", {31'b0, load_error}, 32'd1);
    check("t5_wr_count", wa_q.size(), 32'd0);
    do_reset();
    #1;
    check("t5_rst_error", {31'b0, load_error}, 32'd0);
    check("t5_rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("t5_rst_wr_en", {31'b0, wr_en}, 32'd0);

    // Full 256-word frame
    clear_mon();
    cs = 8'h00;
    tx_q = '{8'hA5, 8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      w = pat(i);
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(w[b*8 +: 8]);
        cs = cs ^ w[b*8 +: 8];
      end
    end
    tx_q.push_back(cs);
    send_queue();
    check("t6_wr_count", wa_q.size(), 32'd256);
    bad = 0;
    if (wa_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== pat(i)) bad++;
      end
      check("t6_last_addr", wa_q[255], 32'h3FC);
      check("t6_last_data", wd_q[255], pat(255));
    end
    check("t6_words_bad", bad, 32'd0);
    check("t6_consec_wr", consec_cnt, 32'd0);
    check("t6_done_cnt", done_cnt, 32'd1);
    check("t6_hold_after", {31'b0, cpu_hold}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
